// File: rtl/stream_wm_pkg.sv
// stream_wm_pkg: shared state encoding and sizing helpers for the stream write master
package stream_wm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO; a push into a full FIFO succeeds when a pop frees a slot the same cycle
module sync_fifo
  import stream_wm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == CW'(DEPTH);
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    do_pop  = pop && cnt_q != '0;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/stream_write_master.sv
// stream_write_master: buffers a backpressure-free sample stream and writes it to consecutive Avalon-MM words
module stream_write_master
  import stream_wm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                ctrl_start,
  input  logic [ADDR_W-1:0]   ctrl_base_addr,
  input  logic [LEN_W-1:0]    ctrl_length,
  output logic                ctrl_busy,
  output logic                ctrl_done,
  output logic                ctrl_overflow,
  input  logic [DATA_W-1:0]   d_in,
  input  logic                v,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest
);
  localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
  localparam int CW = ptr_w(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, acc_q, acc_d, wcnt_q, wcnt_d;
  logic ovf_q, ovf_d, wr_q, wr_d;
  logic want, push, pop, start, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push(push),
    .pop(pop),
    .wdata(d_in),
    .rdata(fifo_head),
    .full(fifo_full),
    .count(fifo_count)
  );
  // write is requested only for data already buffered, giving one cycle of latency from accept
  always_comb begin
    pop     = wr_q && !avm_waitrequest;
    want    = v && state_q == RUN && acc_q < len_q;
    push    = want && (!fifo_full || pop);
    start   = ctrl_start && state_q == IDLE;
    addr_d  = start ? ctrl_base_addr : pop ? addr_q + ADDR_W'(BYTES_PER_WORD) : addr_q;
    len_d   = start ? ctrl_length : len_q;
    acc_d   = start ? '0 : acc_q + LEN_W'(push);
    wcnt_d  = start ? '0 : wcnt_q + LEN_W'(pop);
    ovf_d   = !start && (ovf_q || (want && !push));
    state_d = start ? (ctrl_length == '0 ? DONE : RUN)
            : state_q == RUN && wcnt_d == len_q ? DONE
            : state_q == DONE ? IDLE : state_q;
    wr_d    = state_d == RUN && fifo_count != CW'(pop);
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
    end
  end
  assign ctrl_busy      = state_q == RUN;
  assign ctrl_done      = state_q == DONE;
  assign ctrl_overflow  = ovf_q;
  assign avm_write      = wr_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wr_q ? fifo_head : '0;
  assign avm_byteenable = '1;
endmodule

// File: tb/tb_stream_write_master.sv
// tb_stream_write_master: randomized scenarios scored against a queue-based model of the write master
module tb_stream_write_master;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 32;
  localparam int LEN_W = 16;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_reset = 1'b1, ctrl_start = 1'b0, v = 1'b0, avm_waitrequest = 1'b0;
  logic [ADDR_W-1:0] ctrl_base_addr = '0;
  logic [LEN_W-1:0] ctrl_length = '0;
  logic [DATA_W-1:0] d_in = '0;
  logic ctrl_busy, ctrl_done, ctrl_overflow, avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  int checks = 0, errors = 0;
  // reference model state, updated at every falling edge
  bit m_busy = 0, m_ovf = 0;
  int m_len = 0, acc = 0, occ = 0, nwr = 0, done_cnt = 0, wr_total = 0;
  logic [ADDR_W-1:0] m_base = '0;
  logic [DATA_W-1:0] exp_data[$], got_data[$];
  logic [ADDR_W-1:0] got_addr[$];
  stream_write_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .ctrl_start(ctrl_start),
    .ctrl_base_addr(ctrl_base_addr),
    .ctrl_length(ctrl_length),
    .ctrl_busy(ctrl_busy),
    .ctrl_done(ctrl_done),
    .ctrl_overflow(ctrl_overflow),
    .d_in(d_in),
    .v(v),
    .avm_address(avm_address),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );
  always @(negedge clk) begin
    bit pop;
    pop = avm_write && !avm_waitrequest;
    if (reset_reset) begin
      m_busy = 0;
      occ = 0;
    end else begin
      if (pop) begin
        got_addr.push_back(avm_address);
        got_data.push_back(avm_writedata);
        wr_total++;
      end
      if (ctrl_done) done_cnt++;
      if (m_busy && v && acc < m_len) begin
        if (occ < DEPTH || pop) begin
          exp_data.push_back(d_in);
          acc++;
          occ++;
        end else m_ovf = 1;
      end
      if (pop && occ > 0) begin
        occ--;
        nwr++;
        if (nwr == m_len) m_busy = 0;
      end
      if (ctrl_start && !m_busy) begin
        m_len = int'(ctrl_length);
        m_base = ctrl_base_addr;
        m_busy = ctrl_length != 0;
        m_ovf = 0;
        acc = 0;
        occ = 0;
        nwr = 0;
        done_cnt = 0;
        exp_data.delete();
        got_data.delete();
        got_addr.delete();
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [ADDR_W-1:0] base, input int len);
    ctrl_start = 1'b1;
    ctrl_base_addr = base;
    ctrl_length = LEN_W'(len);
    cyc();
    ctrl_start = 1'b0;
  endtask
  task automatic run_cycles(input int budget, input int vpct, input int wpct, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      v = int'($urandom_range(99)) < vpct;
      d_in = DATA_W'($urandom);
      avm_waitrequest = int'($urandom_range(99)) < wpct;
      cyc();
      if (ctrl_done) begin
        ok = 1;
        break;
      end
    end
    v = 1'b0;
    avm_waitrequest = 1'b0;
    cyc();
  endtask
  task automatic test_reset();
    reset_reset = 1'b1;
    cyc();
    cyc();
    reset_reset = 1'b0;
    cyc();
    checks++;
    if ({ctrl_busy, ctrl_done, ctrl_overflow, avm_write} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {ctrl_busy, ctrl_done, ctrl_overflow, avm_write});
    end
    checks++;
    if (avm_address !== '0 || avm_writedata !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr %h data %h exp 0 0", avm_address, avm_writedata);
    end
    checks++;
    if (avm_byteenable !== 2'b11) begin
      errors++;
      $display("FAIL byteenable got %b exp 11", avm_byteenable);
    end
  endtask
  task automatic test_basic();
    bit ok;
    avm_waitrequest = 1'b0;
    start(32'h1000, 4);
    for (int i = 0; i < 4; i++) begin
      v = 1'b1;
      d_in = DATA_W'(16'hA001 + i);
      cyc();
      if (i == 0) begin
        checks++;
        if (avm_write !== 1'b0) begin
          errors++;
          $display("FAIL latency_early got write %b exp 0", avm_write);
        end
      end
      if (i == 1) begin
        checks++;
        if (avm_write !== 1'b1 || avm_writedata !== 16'hA001 || avm_address !== 32'h1000) begin
          errors++;
          $display("FAIL latency_first got w %b a %h d %h exp 1 1000 a001", avm_write, avm_address, avm_writedata);
        end
      end
    end
    v = 1'b0;
    run_cycles(50, 0, 0, ok);
    checks++;
    if (!ok || got_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count got done %0d writes %0d exp 1 4", ok, got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 4; i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(32'h1000 + 2 * i) || got_data[i] !== DATA_W'(16'hA001 + i)) begin
        errors++;
        $display("FAIL basic_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], 32'h1000 + 2 * i, 16'hA001 + i);
      end
    end
    checks++;
    if (done_cnt != 1 || ctrl_busy !== 1'b0 || ctrl_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_status got done_cnt %0d busy %b ovf %b exp 1 0 0", done_cnt, ctrl_busy, ctrl_overflow);
    end
  endtask
  task automatic test_stall();
    int left = 0, sent = 0;
    bit begun = 0, ok = 0;
    logic [ADDR_W-1:0] ha = '0;
    logic [DATA_W-1:0] hd = '0;
    start(32'h3000, 8);
    for (int k = 0; k < 100; k++) begin
      v = sent < 8;
      d_in = DATA_W'($urandom);
      if (v) sent++;
      if (!begun && got_data.size() > 0) begin
        begun = 1;
        left = 6;
      end
      avm_waitrequest = left > 0;
      cyc();
      if (avm_waitrequest) begin
        if (left == 6) begin
          ha = avm_address;
          hd = avm_writedata;
        end else begin
          checks++;
          if (avm_write !== 1'b1 || avm_address !== ha || avm_writedata !== hd) begin
            errors++;
            $display("FAIL stall_hold got w %b %h/%h exp 1 %h/%h", avm_write, avm_address, avm_writedata, ha, hd);
          end
        end
        left--;
      end
      if (ctrl_done) begin
        ok = 1;
        break;
      end
    end
    v = 1'b0;
    avm_waitrequest = 1'b0;
    cyc();
    checks++;
    if (!ok || got_data.size() != 8 || exp_data.size() != 8) begin
      errors++;
      $display("FAIL stall_count got done %0d writes %0d accepted %0d exp 1 8 8", ok, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(32'h3000 + 2 * i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL stall_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], 32'h3000 + 2 * i, exp_data[i]);
      end
    end
    checks++;
    if (ctrl_overflow !== 1'b0) begin
      errors++;
      $display("FAIL stall_ovf got %b exp 0", ctrl_overflow);
    end
  endtask
  task automatic test_overflow();
    bit ok = 0;
    logic [DATA_W-1:0] sent[$];
    avm_waitrequest = 1'b1;
    start(32'h8000, 20);
    for (int k = 0; k < 300; k++) begin
      v = 1'b1;
      d_in = DATA_W'($urandom);
      sent.push_back(d_in);
      avm_waitrequest = k < 20;
      cyc();
      if (k == 19) begin
        checks++;
        if (ctrl_overflow !== 1'b1 || avm_write !== 1'b1 || got_data.size() != 0) begin
          errors++;
          $display("FAIL ovf_stalled got ovf %b w %b writes %0d exp 1 1 0", ctrl_overflow, avm_write, got_data.size());
        end
      end
      if (ctrl_done) begin
        ok = 1;
        break;
      end
    end
    v = 1'b0;
    avm_waitrequest = 1'b0;
    cyc();
    checks++;
    if (!ok || got_data.size() != 20 || exp_data.size() != 20) begin
      errors++;
      $display("FAIL ovf_count got done %0d writes %0d accepted %0d exp 1 20 20", ok, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(32'h8000 + 2 * i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL ovf_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], 32'h8000 + 2 * i, exp_data[i]);
      end
    end
    if (got_data.size() > 16 && sent.size() > 20) begin
      checks++;
      if (got_data[15] !== sent[15] || got_data[16] !== sent[20]) begin
        errors++;
        $display("FAIL ovf_drop got %h %h exp %h %h", got_data[15], got_data[16], sent[15], sent[20]);
      end
    end
    checks++;
    if (ctrl_overflow !== 1'b1 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky got ovf %b busy %b exp 1 0", ctrl_overflow, ctrl_busy);
    end
  endtask
  task automatic test_zero_idle();
    int w0;
    start(32'h0, 0);
    checks++;
    if (ctrl_done !== 1'b1 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done %b busy %b exp 1 0", ctrl_done, ctrl_busy);
    end
    cyc();
    checks++;
    if (ctrl_done !== 1'b0 || ctrl_overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_after got done %b ovf %b exp 0 0", ctrl_done, ctrl_overflow);
    end
    w0 = wr_total;
    for (int k = 0; k < 12; k++) begin
      v = 1'($urandom);
      d_in = DATA_W'($urandom);
      cyc();
    end
    v = 1'b0;
    cyc();
    checks++;
    if (wr_total != w0 || avm_write !== 1'b0 || ctrl_overflow !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL idle_ignore got writes %0d w %b ovf %b dones %0d exp %0d 0 0 1", wr_total, avm_write, ctrl_overflow, done_cnt, w0);
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    avm_waitrequest = 1'b1;
    start(32'h4000, 8);
    for (int k = 0; k < 6; k++) begin
      v = 1'b1;
      d_in = DATA_W'($urandom);
      cyc();
    end
    v = 1'b0;
    checks++;
    if (avm_write !== 1'b1 || ctrl_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_stalled got w %b busy %b exp 1 1", avm_write, ctrl_busy);
    end
    reset_reset = 1'b1;
    cyc();
    checks++;
    if (avm_write !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got w %b busy %b exp 0 0", avm_write, ctrl_busy);
    end
    reset_reset = 1'b0;
    avm_waitrequest = 1'b0;
    cyc();
    start(32'h2000, 2);
    for (int k = 0; k < 2; k++) begin
      v = 1'b1;
      d_in = DATA_W'(16'hC0DE + k);
      cyc();
    end
    v = 1'b0;
    run_cycles(50, 0, 0, ok);
    checks++;
    if (!ok || got_data.size() != 2) begin
      errors++;
      $display("FAIL mid_restart got done %0d writes %0d exp 1 2", ok, got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(32'h2000 + 2 * i) || got_data[i] !== DATA_W'(16'hC0DE + i)) begin
        errors++;
        $display("FAIL mid_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], 32'h2000 + 2 * i, 16'hC0DE + i);
      end
    end
  endtask
  task automatic test_start_busy_wrap();
    bit ok;
    logic [ADDR_W-1:0] a;
    start(32'h5000, 6);
    for (int k = 0; k < 3; k++) begin
      v = 1'b1;
      d_in = DATA_W'($urandom);
      cyc();
    end
    ctrl_start = 1'b1;
    ctrl_base_addr = 32'h9000;
    ctrl_length = 16'd3;
    d_in = DATA_W'($urandom);
    cyc();
    ctrl_start = 1'b0;
    run_cycles(300, 60, 30, ok);
    checks++;
    if (!ok || got_data.size() != 6 || exp_data.size() != 6 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start got done %0d writes %0d accepted %0d dones %0d exp 1 6 6 1", ok, got_data.size(), exp_data.size(), done_cnt);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== ADDR_W'(32'h5000 + 2 * i) || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL busy_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], 32'h5000 + 2 * i, exp_data[i]);
      end
    end
    start(32'hFFFF_FFFE, 2);
    for (int k = 0; k < 2; k++) begin
      v = 1'b1;
      d_in = DATA_W'($urandom);
      cyc();
    end
    v = 1'b0;
    run_cycles(50, 0, 0, ok);
    checks++;
    if (!ok || got_data.size() != 2) begin
      errors++;
      $display("FAIL wrap_count got done %0d writes %0d exp 1 2", ok, got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 2; i++) begin
      a = (i == 0) ? 32'hFFFF_FFFE : 32'h0;
      checks++;
      if (got_addr[i] !== a || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_write%0d got %h/%h exp %h/%h", i, got_addr[i], got_data[i], a, exp_data[i]);
      end
    end
  endtask
  task automatic test_random();
    bit ok;
    int len;
    logic [ADDR_W-1:0] base, a;
    for (int t = 0; t < 6; t++) begin
      base = ADDR_W'($urandom) & ~ADDR_W'(1);
      len = int'($urandom_range(40, 1));
      start(base, len);
      run_cycles(3000, int'($urandom_range(100, 30)), int'($urandom_range(60, 0)), ok);
      checks++;
      if (!ok || got_data.size() != len || exp_data.size() != len || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_count got done %0d writes %0d accepted %0d dones %0d exp 1 %0d %0d 1", t, ok, got_data.size(), exp_data.size(), done_cnt, len, len);
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
        a = base + ADDR_W'(2 * i);
        checks++;
        if (got_addr[i] !== a || got_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %h/%h exp %h/%h", t, i, got_addr[i], got_data[i], a, exp_data[i]);
        end
      end
      checks++;
      if (ctrl_overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand%0d_ovf got %b exp %b", t, ctrl_overflow, m_ovf);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_zero_idle();
    test_reset_mid();
    test_start_busy_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_write_master.md
Name: stream_write_master

Overview:
- Avalon-MM write master that takes the 16-bit sample stream (d_in/v) and writes it to consecutive memory words.
- It is the writer counterpart to the stream read master, which fetches memory and emits d_out/vout.
- It sits inside the LPC Qsys system, fed by the processing datapath. It is driven by a start/base/length control port and reports busy/done/overflow.
- The stream source has no backpressure, so an internal FIFO absorbs Avalon waitrequest stalls.

Parameters:
- DATA_W, 16, stream and Avalon writedata width in bits (multiple of 8)
- ADDR_W, 32, Avalon byte address width
- LEN_W, 16, width of the transfer length in samples
- FIFO_DEPTH, 16, sample buffer depth (power of 2, at least 4)

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset  in  1  synchronous, active-high reset
- ctrl_start  in  1  one-cycle pulse that starts a transfer; ignored while busy
- ctrl_base_addr  in  ADDR_W  byte address of the first sample; sampled on start
- ctrl_length  in  LEN_W  number of samples to write; sampled on start
- ctrl_busy  out  1  high from the cycle after an accepted start until done
- ctrl_done  out  1  one-cycle pulse when the last write completes
- ctrl_overflow  out  1  sticky: a sample was dropped because the FIFO was full; cleared on start
- d_in  in  DATA_W  stream sample
- v  in  1  d_in valid this cycle
- avm_address  out  ADDR_W  write byte address
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_byteenable  out  DATA_W/8  always all ones
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE and the FIFO is emptied.
  - Counters are cleared.
  - ctrl_busy=0, ctrl_done=0, ctrl_overflow=0, avm_write=0, avm_address=0, avm_writedata=0.
  - Reset mid-transfer aborts immediately. avm_write is low in the cycle after reset is seen, even if waitrequest is high. Buffered data is discarded.
- States:
  - IDLE:
    - ctrl_start loads addr_q=base and remaining counts.
    - Clears overflow and accept/write counters, then goes to RUN.
    - If ctrl_length==0, goes straight to DONE with no Avalon writes.
  - RUN: accepts samples and issues writes. Goes to DONE when write_cnt reaches length.
  - DONE: ctrl_done=1 for exactly one cycle, ctrl_busy=0, then IDLE.
- Stream accept:
  - A sample is accepted when v=1, state is RUN, accept_cnt<length, and the FIFO is not full.
  - Accepted samples are pushed and accept_cnt increments.
  - v=1 with the FIFO full in RUN: sample dropped, ctrl_overflow set, accept_cnt not incremented. The transfer still waits for length samples.
  - v outside RUN, or after accept_cnt==length: silently ignored, no overflow.
- Avalon write:
  - avm_write is registered. It asserts in RUN when the FIFO is not empty.
  - avm_address=addr_q and avm_writedata=FIFO head.
  - While avm_write=1 and avm_waitrequest=1: address, data and write held stable.
  - On avm_write=1 and avm_waitrequest=0: pop, addr_q += DATA_W/8 (wraps modulo 2^ADDR_W), write_cnt++.
  - avm_write is deasserted the next cycle if the FIFO becomes empty or write_cnt reaches length.
  - Back-to-back writes sustain one per cycle when waitrequest=0.
- Latency: sample with v=1 at edge t → avm_write=1 with that data at the output after edge t+1 (earliest), i.e. one cycle.
- Simultaneous push and pop with the FIFO full: the push is accepted (slot frees the same cycle). No overflow.
- Any ctrl_start while ctrl_busy is ignored and has no side effects.

Decomposition:
- Package stream_wm_pkg:
  - State enum {IDLE, RUN, DONE}.
  - BYTES_PER_WORD = DATA_W/8.
  - FIFO pointer width = $clog2(FIFO_DEPTH).
- Submodule sync_fifo (DATA_W × FIFO_DEPTH, show-ahead head, full/empty, same-cycle push+pop). The control FSM and Avalon logic stay in stream_write_master.

Test Plan:
- Basic burst:
  - Stimulus: base=0x1000, length=4, v high 4 cycles with 0xA001..0xA004, waitrequest=0.
  - Required: writes to 0x1000, 0x1002, 0x1004, 0x1006 with those data; ctrl_done pulses once; busy low after; overflow=0.
- Stall absorption:
  - Stimulus: length=8, continuous v, waitrequest high for 6 cycles after the first write.
  - Required: address and data held during the stall; all 8 writes in order; overflow=0.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, length=20, continuous v, waitrequest stuck high for 20 cycles.
  - Required: samples 17 onward dropped; overflow=1; after release, writes resume; transfer completes once 20 accepted samples are written.
- Zero length and ignored input:
  - Stimulus: length=0 start.
  - Required: ctrl_done pulse within 2 cycles, no avm_write. v pulses while IDLE produce no writes and no overflow.
- Reset mid-op:
  - Stimulus: reset_reset asserted during a stalled write with length=8.
  - Required: avm_write=0 next cycle; busy=0; new start base=0x2000, length=2 writes exactly 0x2000 and 0x2002.
- Start while busy and wrap:
  - Stimulus: ctrl_start during RUN; separately base=0xFFFFFFFE, length=2.
  - Required: the start during RUN is ignored; addresses 0xFFFFFFFE then 0x00000000.
